// File: rtl/segre_mem_req_arbiter_if.sv
// Client-side request/response and memory-side signals of segre_mem_req_arbiter.
// slave: the arbiter's view; master: the clients' and memory's view.
interface segre_mem_req_arbiter_if #(
   parameter int unsigned NUM_CLIENTS = 2,
   parameter int unsigned BUF_DEPTH   = 16,
   parameter int unsigned ADDR_W      = 32,
   parameter int unsigned LINE_BYTES  = 16,
   parameter int unsigned ID_W        = $clog2(NUM_CLIENTS)
);
   localparam int unsigned LINE_W = 8 * LINE_BYTES;
   localparam int unsigned OCC_W  = $clog2(BUF_DEPTH + 1);

   logic [NUM_CLIENTS-1:0]        cli_valid_i;
   logic [NUM_CLIENTS-1:0]        cli_rd_i;
   logic [NUM_CLIENTS-1:0]        cli_wr_i;
   logic [NUM_CLIENTS*ADDR_W-1:0] cli_addr_i;
   logic [NUM_CLIENTS*LINE_W-1:0] cli_line_i;
   logic [NUM_CLIENTS-1:0]        cli_ready_o;
   logic [NUM_CLIENTS-1:0]        cli_rsp_valid_o;
   logic [LINE_W-1:0]             cli_rsp_line_o;

   logic                          mem_req_valid_o;
   logic                          mem_req_ready_i;
   logic                          mem_req_rd_o;
   logic                          mem_req_wr_o;
   logic [ADDR_W-1:0]             mem_req_addr_o;
   logic [LINE_W-1:0]             mem_req_line_o;
   logic [ID_W-1:0]               mem_req_id_o;
   logic                          mem_rsp_valid_i;
   logic [LINE_W-1:0]             mem_rsp_line_i;

   logic [OCC_W-1:0]              occupancy_o;
   logic                          err_o;

   modport slave (
      input  cli_valid_i, cli_rd_i, cli_wr_i, cli_addr_i, cli_line_i,
      output cli_ready_o, cli_rsp_valid_o, cli_rsp_line_o,
      output mem_req_valid_o, mem_req_rd_o, mem_req_wr_o, mem_req_addr_o,
      output mem_req_line_o, mem_req_id_o,
      input  mem_req_ready_i, mem_rsp_valid_i, mem_rsp_line_i,
      output occupancy_o, err_o
   );

   modport master (
      output cli_valid_i, cli_rd_i, cli_wr_i, cli_addr_i, cli_line_i,
      input  cli_ready_o, cli_rsp_valid_o, cli_rsp_line_o,
      input  mem_req_valid_o, mem_req_rd_o, mem_req_wr_o, mem_req_addr_o,
      input  mem_req_line_o, mem_req_id_o,
      output mem_req_ready_i, mem_rsp_valid_i, mem_rsp_line_i,
      input  occupancy_o, err_o
   );
endinterface

// File: rtl/segre_mem_req_arbiter.sv
// N-client round-robin arbiter with in-order request FIFO towards one memory port,
// an outstanding-read limit and in-order read-response routing back to the issuer.
module segre_mem_req_arbiter #(
   parameter int unsigned NUM_CLIENTS = 2,
   parameter int unsigned BUF_DEPTH   = 16,
   parameter int unsigned MAX_RD_OUT  = 4,
   parameter int unsigned ADDR_W      = 32,
   parameter int unsigned LINE_BYTES  = 16,
   parameter int unsigned ID_W        = $clog2(NUM_CLIENTS)
) (
   input  logic                   clk_i,
   input  logic                   rsn_i,
   segre_mem_req_arbiter_if.slave bus
);
   localparam int unsigned LINE_W = 8 * LINE_BYTES;
   localparam int unsigned PTR_W  = $clog2(BUF_DEPTH);
   localparam int unsigned OCC_W  = $clog2(BUF_DEPTH + 1);
   localparam int unsigned RQ_PW  = (MAX_RD_OUT > 1) ? $clog2(MAX_RD_OUT) : 1;
   localparam int unsigned RQ_CW  = $clog2(MAX_RD_OUT + 1);

   typedef struct packed {
      logic [ID_W-1:0]   id;
      logic              rd;
      logic              wr;
      logic [ADDR_W-1:0] addr;
      logic [LINE_W-1:0] line;
   } req_t;

   logic [ID_W-1:0]  r_rr_ptr;
   req_t             r_buf [BUF_DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [OCC_W-1:0] r_count;
   logic [ID_W-1:0]  r_idq [MAX_RD_OUT];
   logic [RQ_PW-1:0] r_idq_wr;
   logic [RQ_PW-1:0] r_idq_rd;
   logic [RQ_CW-1:0] r_rd_out;
   logic             r_err;

   logic             w_gnt_found;
   logic [ID_W-1:0]  w_gnt_idx;
   logic             w_full;
   logic             w_accept;
   req_t             w_in;
   req_t             w_head;
   logic             w_empty;
   logic             w_rd_full;
   logic             w_rsp;
   logic             w_req_valid;
   logic             w_issue;
   logic             w_issue_rd;

   function automatic logic [ID_W-1:0] f_rr_idx(input logic [ID_W-1:0] base, input int unsigned off);
      int unsigned s;
      s = 32'(base) + off;
      if (s >= NUM_CLIENTS) s = s - NUM_CLIENTS;
      return ID_W'(s);
   endfunction

   function automatic logic [RQ_PW-1:0] f_rq_inc(input logic [RQ_PW-1:0] p);
      return (p == RQ_PW'(MAX_RD_OUT - 1)) ? '0 : p + 1'b1;
   endfunction

   // Round-robin search starting at r_rr_ptr.
   always_comb begin
      w_gnt_found = 1'b0;
      w_gnt_idx   = '0;
      for (int unsigned i = 0; i < NUM_CLIENTS; i++) begin
         if (!w_gnt_found && bus.cli_valid_i[f_rr_idx(r_rr_ptr, i)]) begin
            w_gnt_found = 1'b1;
            w_gnt_idx   = f_rr_idx(r_rr_ptr, i);
         end
      end
   end

   assign w_full   = (r_count == OCC_W'(BUF_DEPTH));
   assign w_accept = w_gnt_found && !w_full;

   assign w_in.id   = w_gnt_idx;
   assign w_in.rd   = bus.cli_rd_i[w_gnt_idx];
   assign w_in.wr   = bus.cli_wr_i[w_gnt_idx];
   assign w_in.addr = bus.cli_addr_i[32'(w_gnt_idx) * ADDR_W +: ADDR_W];
   assign w_in.line = bus.cli_line_i[32'(w_gnt_idx) * LINE_W +: LINE_W];

   assign w_head    = r_buf[r_rd_ptr];
   assign w_empty   = (r_count == '0);
   assign w_rd_full = (r_rd_out == RQ_CW'(MAX_RD_OUT));
   assign w_rsp     = bus.mem_rsp_valid_i && (r_rd_out != '0);

   // A response in the same cycle frees a slot, so a read at the limit may still go out.
   assign w_req_valid = !w_empty && !(w_head.rd && w_rd_full && !w_rsp);
   assign w_issue     = w_req_valid && bus.mem_req_ready_i;
   assign w_issue_rd  = w_issue && w_head.rd;

   // Ready is forced low while reset is held so it does not follow cli_valid_i then.
   assign bus.cli_ready_o     = (w_accept && rsn_i) ? (NUM_CLIENTS'(1) << w_gnt_idx) : '0;
   assign bus.cli_rsp_valid_o = w_rsp ? (NUM_CLIENTS'(1) << r_idq[r_idq_rd]) : '0;
   assign bus.cli_rsp_line_o  = bus.mem_rsp_line_i;

   assign bus.mem_req_valid_o = w_req_valid;
   assign bus.mem_req_rd_o    = w_head.rd;
   assign bus.mem_req_wr_o    = w_head.wr;
   assign bus.mem_req_addr_o  = w_head.addr;
   assign bus.mem_req_line_o  = w_head.line;
   assign bus.mem_req_id_o    = w_head.id;

   assign bus.occupancy_o = r_count;
   assign bus.err_o       = r_err;

   always_ff @(posedge clk_i or negedge rsn_i) begin
      if (!rsn_i) begin
         r_rr_ptr <= '0;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_idq_wr <= '0;
         r_idq_rd <= '0;
         r_rd_out <= '0;
         r_err    <= 1'b0;
      end else begin
         if (w_accept) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
            r_rr_ptr <= (w_gnt_idx == ID_W'(NUM_CLIENTS - 1)) ? '0 : w_gnt_idx + 1'b1;
         end
         if (w_issue) r_rd_ptr <= r_rd_ptr + 1'b1;
         if (w_accept && !w_issue)      r_count <= r_count + 1'b1;
         else if (!w_accept && w_issue) r_count <= r_count - 1'b1;

         if (w_issue_rd) r_idq_wr <= f_rq_inc(r_idq_wr);
         if (w_rsp)      r_idq_rd <= f_rq_inc(r_idq_rd);
         if (w_issue_rd && !w_rsp)      r_rd_out <= r_rd_out + 1'b1;
         else if (!w_issue_rd && w_rsp) r_rd_out <= r_rd_out - 1'b1;

         if (bus.mem_rsp_valid_i && (r_rd_out == '0)) r_err <= 1'b1;
      end
   end

   // Payload storage carries no reset; occupancy and pointers qualify it.
   always_ff @(posedge clk_i) begin
      if (w_accept)   r_buf[r_wr_ptr] <= w_in;
      if (w_issue_rd) r_idq[r_idq_wr] <= w_head.id;
   end
endmodule

// File: tb/tb_segre_mem_req_arbiter.sv
// Testbench for segre_mem_req_arbiter: directed corner sequences, a round-robin
// vector table, and randomized traffic against a queue-based reference model.
module tb_segre_mem_req_arbiter;
   localparam int unsigned NC   = 4;
   localparam int unsigned BD   = 16;
   localparam int unsigned MRO  = 4;
   localparam int unsigned AW   = 32;
   localparam int unsigned LB   = 16;
   localparam int unsigned LW   = 8 * LB;
   localparam int unsigned IDW  = 2;
   localparam int unsigned NRND = 3000;

   logic clk = 1'b0;
   logic rsn = 1'b0;
   always #5 clk = ~clk;

   segre_mem_req_arbiter_if #(.NUM_CLIENTS(NC), .BUF_DEPTH(BD), .ADDR_W(AW),
                              .LINE_BYTES(LB), .ID_W(IDW)) bus ();

   segre_mem_req_arbiter #(.NUM_CLIENTS(NC), .BUF_DEPTH(BD), .MAX_RD_OUT(MRO),
                           .ADDR_W(AW), .LINE_BYTES(LB), .ID_W(IDW))
      dut (.clk_i(clk), .rsn_i(rsn), .bus(bus));

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // ---------------- reference model: plain queues ----------------
   typedef struct {
      int            id;
      bit            rd;
      bit            wr;
      logic [AW-1:0] addr;
      logic [LW-1:0] line;
   } ent_t;

   ent_t m_fifo[$];
   int   m_idq[$];
   int   m_rr;
   bit   m_err;

   function automatic void model_reset();
      m_fifo.delete();
      m_idq.delete();
      m_rr  = 0;
      m_err = 0;
   endfunction

   // Check this cycle's outputs against the model, then advance the model.
   task automatic model_cycle();
      int         g;
      int         c;
      bit         accept;
      bit         rsp_ok;
      bit         memv;
      logic [NC-1:0] exp_ready;
      logic [NC-1:0] exp_rsp;
      ent_t       e;
      g = -1;
      exp_ready = '0;
      exp_rsp   = '0;
      for (int i = 0; i < NC; i++) begin
         c = (m_rr + i) % NC;
         if (g < 0 && bus.cli_valid_i[c]) g = c;
      end
      accept = (g >= 0) && (m_fifo.size() < BD);
      if (accept) exp_ready[g] = 1'b1;
      rsp_ok = bus.mem_rsp_valid_i && (m_idq.size() > 0);
      if (rsp_ok) exp_rsp[m_idq[0]] = 1'b1;
      memv = (m_fifo.size() > 0) && !(m_fifo[0].rd && m_idq.size() == MRO && !rsp_ok);

      chk("rnd_ready", LW'(bus.cli_ready_o), LW'(exp_ready));
      chk("rnd_memv", LW'(bus.mem_req_valid_o), LW'(memv));
      chk("rnd_occ", LW'(bus.occupancy_o), LW'(m_fifo.size()));
      chk("rnd_err", LW'(bus.err_o), LW'(m_err));
      chk("rnd_rspv", LW'(bus.cli_rsp_valid_o), LW'(exp_rsp));
      if (rsp_ok) chk("rnd_rsp_line", bus.cli_rsp_line_o, bus.mem_rsp_line_i);
      if (memv) begin
         chk("rnd_req_id", LW'(bus.mem_req_id_o), LW'(m_fifo[0].id));
         chk("rnd_req_rdwr", LW'({bus.mem_req_rd_o, bus.mem_req_wr_o}), LW'({m_fifo[0].rd, m_fifo[0].wr}));
         chk("rnd_req_addr", LW'(bus.mem_req_addr_o), LW'(m_fifo[0].addr));
         chk("rnd_req_line", bus.mem_req_line_o, m_fifo[0].line);
      end

      if (rsp_ok) void'(m_idq.pop_front());
      else if (bus.mem_rsp_valid_i) m_err = 1;
      if (memv && bus.mem_req_ready_i) begin
         e = m_fifo.pop_front();
         if (e.rd) m_idq.push_back(e.id);
      end
      if (accept) begin
         e.id   = g;
         e.rd   = bus.cli_rd_i[g];
         e.wr   = bus.cli_wr_i[g];
         e.addr = bus.cli_addr_i[g*AW +: AW];
         e.line = bus.cli_line_i[g*LW +: LW];
         m_fifo.push_back(e);
         m_rr = (g + 1) % NC;
      end
   endtask

   // ---------------- stimulus helpers ----------------
   task automatic clr_inputs();
      bus.cli_valid_i     = '0;
      bus.cli_rd_i        = '0;
      bus.cli_wr_i        = '0;
      bus.cli_addr_i      = '0;
      bus.cli_line_i      = '0;
      bus.mem_req_ready_i = 1'b0;
      bus.mem_rsp_valid_i = 1'b0;
      bus.mem_rsp_line_i  = '0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rsn = 1'b0;
      clr_inputs();
      repeat (2) @(posedge clk);
      #1;
      rsn = 1'b1;
      model_reset();
   endtask

   task automatic set_req(input int c, input bit rd, input bit wr, input logic [AW-1:0] addr);
      bus.cli_valid_i[c]          = 1'b1;
      bus.cli_rd_i[c]             = rd;
      bus.cli_wr_i[c]             = wr;
      bus.cli_addr_i[c*AW +: AW]  = addr;
      bus.cli_line_i[c*LW +: LW]  = {4{addr}};
   endtask

   typedef struct {
      bit          do_rst;
      logic [NC-1:0] valid;
      logic [NC-1:0] exp_ready;
      int          exp_occ;
   } rr_vec_t;

   rr_vec_t      rr_tab[9];
   int           issues;
   logic [LW-1:0] a5_line;
   logic [LW-1:0] tmp_line;

   initial begin
      rr_tab[0] = '{1'b1, 4'b1111, 4'b0001, 0};
      rr_tab[1] = '{1'b0, 4'b1111, 4'b0010, 1};
      rr_tab[2] = '{1'b0, 4'b1111, 4'b0100, 1};
      rr_tab[3] = '{1'b0, 4'b1111, 4'b1000, 1};
      rr_tab[4] = '{1'b0, 4'b1111, 4'b0001, 1};
      rr_tab[5] = '{1'b1, 4'b1010, 4'b0010, 0};
      rr_tab[6] = '{1'b0, 4'b1010, 4'b1000, 1};
      rr_tab[7] = '{1'b0, 4'b1010, 4'b0010, 1};
      rr_tab[8] = '{1'b0, 4'b1010, 4'b1000, 1};
      a5_line = {LB{8'hA5}};

      // Reset values, with valid and a response driven while reset is held.
      clr_inputs();
      step();
      bus.cli_valid_i     = 4'b1111;
      bus.mem_rsp_valid_i = 1'b1;
      #1;
      chk("rst_ready", LW'(bus.cli_ready_o), '0);
      chk("rst_rspv", LW'(bus.cli_rsp_valid_o), '0);
      chk("rst_memv", LW'(bus.mem_req_valid_o), '0);
      chk("rst_occ", LW'(bus.occupancy_o), '0);
      chk("rst_err", LW'(bus.err_o), '0);
      do_reset();

      // Single read from client 1, then its response.
      set_req(1, 1'b1, 1'b0, 32'h100);
      #1;
      chk("single_ready", LW'(bus.cli_ready_o), LW'(4'b0010));
      chk("single_nobypass", LW'(bus.mem_req_valid_o), '0);
      step();
      bus.cli_valid_i = '0;
      #1;
      chk("single_memv", LW'(bus.mem_req_valid_o), LW'(1'b1));
      chk("single_id", LW'(bus.mem_req_id_o), LW'(2'd1));
      chk("single_addr", LW'(bus.mem_req_addr_o), LW'(32'h100));
      chk("single_rd", LW'({bus.mem_req_rd_o, bus.mem_req_wr_o}), LW'(2'b10));
      bus.mem_req_ready_i = 1'b1;
      step();
      bus.mem_req_ready_i = 1'b0;
      bus.mem_rsp_valid_i = 1'b1;
      bus.mem_rsp_line_i  = a5_line;
      #1;
      chk("single_rspv", LW'(bus.cli_rsp_valid_o), LW'(4'b0010));
      chk("single_rsp_line", bus.cli_rsp_line_o, a5_line);
      chk("single_occ0", LW'(bus.occupancy_o), '0);
      step();
      bus.mem_rsp_valid_i = 1'b0;
      #1;
      chk("single_rspv_off", LW'(bus.cli_rsp_valid_o), '0);
      chk("single_err", LW'(bus.err_o), '0);

      // Round-robin vector table: writes only, memory always ready.
      for (int i = 0; i < 9; i++) begin
         if (rr_tab[i].do_rst) do_reset();
         bus.cli_valid_i     = rr_tab[i].valid;
         bus.cli_wr_i        = 4'b1111;
         bus.cli_rd_i        = '0;
         bus.mem_req_ready_i = 1'b1;
         #1;
         chk($sformatf("rr_ready[%0d]", i), LW'(bus.cli_ready_o), LW'(rr_tab[i].exp_ready));
         chk($sformatf("rr_occ[%0d]", i), LW'(bus.occupancy_o), LW'(rr_tab[i].exp_occ));
         chk($sformatf("rr_memv[%0d]", i), LW'(bus.mem_req_valid_o), LW'(rr_tab[i].exp_occ > 0));
         step();
      end

      // Full buffer: 16 writes with memory stalled, then a single pop.
      do_reset();
      for (int i = 0; i < 16; i++) begin
         set_req(0, 1'b0, 1'b1, 32'(i));
         step();
      end
      #1;
      chk("full_occ", LW'(bus.occupancy_o), LW'(16));
      chk("full_ready", LW'(bus.cli_ready_o), '0);
      chk("full_head", LW'(bus.mem_req_addr_o), LW'(32'd0));
      bus.mem_req_ready_i = 1'b1;
      #1;
      chk("full_ready_pop", LW'(bus.cli_ready_o), '0);
      step();
      bus.mem_req_ready_i = 1'b0;
      #1;
      chk("full_occ15", LW'(bus.occupancy_o), LW'(15));
      chk("full_ready_again", LW'(bus.cli_ready_o), LW'(4'b0001));
      chk("full_head1", LW'(bus.mem_req_addr_o), LW'(32'd1));
      step();
      #1;
      chk("full_occ16", LW'(bus.occupancy_o), LW'(16));

      // Outstanding-read limit: 6 reads then a write, no responses.
      do_reset();
      for (int i = 0; i < 6; i++) begin
         set_req(2, 1'b1, 1'b0, 32'h200 + 32'(i));
         step();
      end
      bus.cli_valid_i = '0;
      set_req(3, 1'b0, 1'b1, 32'h300);
      step();
      bus.cli_valid_i = '0;
      #1;
      chk("lim_occ7", LW'(bus.occupancy_o), LW'(7));
      bus.mem_req_ready_i = 1'b1;
      issues = 0;
      for (int i = 0; i < 8; i++) begin
         #1;
         if (bus.mem_req_valid_o) issues++;
         step();
      end
      chk("lim_issues4", LW'(issues), LW'(4));
      chk("lim_memv0", LW'(bus.mem_req_valid_o), '0);
      chk("lim_occ3", LW'(bus.occupancy_o), LW'(3));
      bus.mem_rsp_valid_i = 1'b1;
      bus.mem_rsp_line_i  = ~a5_line;
      #1;
      chk("lim_rspv", LW'(bus.cli_rsp_valid_o), LW'(4'b0100));
      issues = 0;
      for (int i = 0; i < 6; i++) begin
         #1;
         if (bus.mem_req_valid_o) issues++;
         step();
         bus.mem_rsp_valid_i = 1'b0;
      end
      #1;
      chk("lim_issues1", LW'(issues), LW'(1));
      chk("lim_blocked", LW'(bus.mem_req_valid_o), '0);
      chk("lim_occ2", LW'(bus.occupancy_o), LW'(2));
      chk("lim_head", LW'(bus.mem_req_addr_o), LW'(32'h205));

      // Response with nothing outstanding.
      do_reset();
      bus.mem_rsp_valid_i = 1'b1;
      #1;
      chk("orphan_rspv", LW'(bus.cli_rsp_valid_o), '0);
      step();
      bus.mem_rsp_valid_i = 1'b0;
      #1;
      chk("orphan_err", LW'(bus.err_o), LW'(1'b1));
      repeat (3) step();
      #1;
      chk("orphan_err_sticky", LW'(bus.err_o), LW'(1'b1));
      do_reset();
      #1;
      chk("orphan_err_clr", LW'(bus.err_o), '0);

      // Asynchronous reset with 5 entries queued.
      do_reset();
      for (int i = 0; i < 5; i++) begin
         set_req(1, 1'b0, 1'b1, 32'h400 + 32'(i));
         step();
      end
      bus.cli_valid_i = 4'b1111;
      #1;
      chk("arst_occ5", LW'(bus.occupancy_o), LW'(5));
      #2;
      rsn = 1'b0;
      #1;
      chk("arst_occ0", LW'(bus.occupancy_o), '0);
      chk("arst_memv", LW'(bus.mem_req_valid_o), '0);
      chk("arst_ready", LW'(bus.cli_ready_o), '0);
      chk("arst_err", LW'(bus.err_o), '0);
      do_reset();

      // Randomized traffic against the reference model.
      for (int n = 0; n < NRND; n++) begin
         bus.cli_valid_i = NC'($urandom);
         bus.cli_rd_i    = NC'($urandom);
         bus.cli_wr_i    = NC'($urandom);
         for (int k = 0; k < NC; k++) bus.cli_addr_i[k*AW +: AW] = $urandom;
         for (int k = 0; k < NC * LW / 32; k++) bus.cli_line_i[k*32 +: 32] = $urandom;
         bus.mem_req_ready_i = ($urandom_range(0, 9) < 7);
         if (m_idq.size() > 0) bus.mem_rsp_valid_i = ($urandom_range(0, 9) < 4);
         else                  bus.mem_rsp_valid_i = (n > NRND / 2) && ($urandom_range(0, 99) < 2);
         for (int k = 0; k < LW / 32; k++) tmp_line[k*32 +: 32] = $urandom;
         bus.mem_rsp_line_i = tmp_line;
         #1;
         model_cycle();
         step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/segre_mem_req_arbiter.md
# segre_mem_req_arbiter

Parametrised N-client arbiter and request buffer between the core's caches (instruction, data, and any future clients) and the single main-memory port. It accepts cache-line read/write requests from NUM_CLIENTS clients under round-robin arbitration, queues them in order in a BUF_DEPTH-entry FIFO, and issues them to memory one at a time. It routes each in-order read response back to the client that issued it. This generalises the fixed two-client (ICACHE/DCACHE) arbiter buffer to any client count and adds response routing plus an outstanding-read limit.

## Interface
Parameters:
- NUM_CLIENTS, 2: requesting clients; client 0 = ICACHE, 1 = DCACHE; must be ≥ 2.
- BUF_DEPTH, 16: request FIFO entries; power of two, ≥ 2.
- MAX_RD_OUT, 4: maximum reads issued to memory without a response; power of two.
- ADDR_W, 32: address width.
- LINE_BYTES, 16: cache line size in bytes; LINE_W = 8*LINE_BYTES.
- ID_W, $clog2(NUM_CLIENTS): client id width.

Ports. One clock; reset is asynchronous and active-low.
- clk_i  in  1  clock; all state updates on the rising edge.
- rsn_i  in  1  asynchronous active-low reset.
- cli_valid_i  in  NUM_CLIENTS  per-client request valid.
- cli_rd_i  in  NUM_CLIENTS  per-client read flag.
- cli_wr_i  in  NUM_CLIENTS  per-client write flag.
- cli_addr_i  in  NUM_CLIENTS*ADDR_W  per-client line address.
- cli_line_i  in  NUM_CLIENTS*LINE_W  per-client write data.
- cli_ready_o  out  NUM_CLIENTS  one-hot accept; the request is taken when valid & ready.
- cli_rsp_valid_o  out  NUM_CLIENTS  one-hot read-response strobe.
- cli_rsp_line_o  out  LINE_W  response data, broadcast to all clients.
- mem_req_valid_o  out  1  memory request valid.
- mem_req_ready_i  in  1  memory accepts the request.
- mem_req_rd_o, mem_req_wr_o  out  1 each  request type.
- mem_req_addr_o  out  ADDR_W  request address.
- mem_req_line_o  out  LINE_W  write data.
- mem_req_id_o  out  ID_W  issuing client.
- mem_rsp_valid_i  in  1  read response valid; one per issued read, in issue order.
- mem_rsp_line_i  in  LINE_W  read response data.
- occupancy_o  out  $clog2(BUF_DEPTH+1)  number of FIFO entries.
- err_o  out  1  sticky protocol error.

## Operation
- **Arbitration**
  - Round-robin pointer rr_ptr, reset value 0.
  - Grant goes to the first client at index rr_ptr, rr_ptr+1, … (mod NUM_CLIENTS) with cli_valid_i set.
  - cli_ready_o is asserted for the granted client only, and only when occupancy_o < BUF_DEPTH. The grant is combinational from cli_valid_i; clients must not make valid depend on ready.
  - On an accepted request from client k: rr_ptr ← (k+1) mod NUM_CLIENTS. With no acceptance, rr_ptr holds.
- **Request FIFO**
  - Each entry stores {id, rd, wr, addr, line}.
  - Push on client handshake; pop on a memory handshake (mem_req_valid_o & mem_req_ready_i).
  - Pointers wrap mod BUF_DEPTH.
  - Full: no push, even if a pop occurs in the same cycle. Empty: no pop.
  - Push and pop in the same cycle leave occupancy unchanged.
- **Issue**
  - mem_req_* fields are driven from the FIFO head.
  - mem_req_valid_o = !empty && !(head.rd && rd_out == MAX_RD_OUT).
  - A stalled read blocks all younger entries; there is no reordering.
  - A request with both rd and wr set is forwarded unchanged and counted as a read.
- **Response tracking**
  - Each issued read pushes its id into an id queue of depth MAX_RD_OUT; rd_out is the queue count.
  - mem_rsp_valid_i pops the queue, asserts cli_rsp_valid_o[id] in the same cycle, and passes mem_rsp_line_i to cli_rsp_line_o combinationally.
  - A read issue and a response in the same cycle leave rd_out unchanged. This case is allowed even when rd_out == MAX_RD_OUT, since the response frees a slot.
  - mem_rsp_valid_i with rd_out == 0 is ignored (no strobe) and sets err_o.
- **Errors**
  - err_o clears only on reset.

## Timing
- Reset values:
  - cli_ready_o = 0, cli_rsp_valid_o = 0.
  - mem_req_valid_o = 0, occupancy_o = 0, err_o = 0.
  - rr_ptr = 0, FIFO and id queue empty.
  - mem_req_* data outputs and cli_rsp_line_o are don't-care (zero is permitted).
- Reset asserted mid-operation discards all queued and outstanding state immediately. Responses to reads issued before reset are then unexpected and set err_o.
- Latency:
  - A request accepted in cycle t is visible on mem_req_valid_o in cycle t+1 at the earliest. There is no bypass.
  - Response: 0 cycles, combinational from mem_rsp_valid_i.
- Throughput: one accept and one issue per cycle.
- mem_req_* outputs hold stable while mem_req_valid_o is high and ready is low.

## Test plan
- **Single request:** NUM_CLIENTS=2. Client 1 reads addr 0x100 at t.
  - cli_ready_o=2'b10 at t; mem_req_valid_o=1 at t+1 with id=1 and addr=0x100.
  - mem_rsp_valid_i with line 0xA5…A5 → cli_rsp_valid_o=2'b10 with that line.
- **Round-robin:** NUM_CLIENTS=4, all clients valid continuously, memory always ready.
  - Grant order is 0,1,2,3,0.
  - With only clients 1 and 3 valid from reset: order is 1,3,1,3.
- **Full:** mem_req_ready_i=0, BUF_DEPTH=16. Push 16 requests.
  - occupancy_o=16 and cli_ready_o=0.
  - Raise ready for 1 cycle → occupancy_o=15, and a push succeeds on the following cycle.
- **Outstanding limit:** MAX_RD_OUT=4, 6 reads queued, no responses.
  - Exactly 4 issues, then mem_req_valid_o=0.
  - One response → one more issue.
  - A write queued behind the stalled read stays blocked.
- **Response with nothing outstanding:** mem_rsp_valid_i with rd_out=0.
  - All cli_rsp_valid_o stay 0 and err_o=1 until reset.
- **Async reset:** assert rsn_i mid-burst with occupancy 5.
  - Outputs go to reset values without waiting for a clock edge; occupancy_o=0.
